// File: rtl/raw_line_framer.sv
// -----------------------------------------------------------------------------
// raw_line_framer
//
// Turns the sensor's level-based stream (frame valid / line valid) into the
// packetised Bayer stream consumed by the demosaic stage. Each forwarded line
// carries raw_sop on its first pixel and raw_eop on its last. The block locks
// only to whole frames, so a frame already in progress when reset is released
// is skipped. The interpolator never sees more than FRAME_LINES lines per frame
// or more than LINE_WIDTH pixels per line.
//
// Pipeline: stage 1 registers the sensor sample. Stage 2 registers the output
// and decides eop by looking at the sample arriving behind it. A pixel present
// on cam_* in cycle n is on raw_* in cycle n+2.
//
// Parameters
//   DATA_WIDTH   pixel width
//   LINE_WIDTH   maximum pixels forwarded per line (longer lines are truncated)
//   FRAME_LINES  lines forwarded per frame (further lines are dropped)
//
// Ports
//   clk              pixel clock
//   reset_n          asynchronous active-low reset
//   cam_data         sensor pixel
//   cam_fval         frame valid (level)
//   cam_lval         line valid (level); a pixel is valid when cam_fval & cam_lval
//   raw_data         pixel to demosaic
//   raw_valid        pixel strobe
//   raw_sop          first pixel of a line (with raw_valid)
//   raw_eop          last pixel of a line (with raw_valid)
//   err_clr          synchronous clear of the sticky error flags
//   err_short_line   sticky: a forwarded line was shorter than LINE_WIDTH
//   err_long_line    sticky: a line was truncated
//   err_frame_lines  sticky: a frame ended with a line count other than FRAME_LINES
//   frame_cnt        completed frames, wraps at 16 bits
//
// Build option
//   RAW_FRAMER_STATUS_EN  compiles in the error flags, frame_cnt and err_clr.
//                         When undefined, err_* and frame_cnt are tied to 0 and
//                         err_clr is ignored. Framing behaves the same either way.
// -----------------------------------------------------------------------------
module raw_line_framer #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_WIDTH  = 1280,
  parameter int FRAME_LINES = 720
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] cam_data,
  input  logic                  cam_fval,
  input  logic                  cam_lval,
  output logic [DATA_WIDTH-1:0] raw_data,
  output logic                  raw_valid,
  output logic                  raw_sop,
  output logic                  raw_eop,
  input  logic                  err_clr,
  output logic                  err_short_line,
  output logic                  err_long_line,
  output logic                  err_frame_lines,
  output logic [15:0]           frame_cnt
);

  // The pixel counter is 12 bits wide. The line counter also has to hold
  // FRAME_LINES + 1, which records one attempted line beyond the limit.
  localparam int PIX_W  = 12;
  localparam int LINE_W = $clog2(FRAME_LINES + 2);

  localparam logic [PIX_W-1:0]  PIX_ONE       = PIX_W'(1);
  localparam logic [PIX_W-1:0]  LINE_WIDTH_C  = PIX_W'(LINE_WIDTH);
  localparam logic [LINE_W-1:0] LINE_ONE      = LINE_W'(1);
  localparam logic [LINE_W-1:0] LINE_ZERO     = LINE_W'(0);
  localparam logic [LINE_W-1:0] FRAME_LINES_C = LINE_W'(FRAME_LINES);

  typedef enum logic [2:0] {
    ST_SYNC       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_WAIT_LINE  = 3'd2,
    ST_IN_LINE    = 3'd3,
    ST_TRUNC      = 3'd4,
    ST_DROP       = 3'd5
  } state_t;

  // Stage 1 sample
  logic [DATA_WIDTH-1:0] s1_data_r;
  logic                  s1_fval_r;
  logic                  s1_lval_r;   // effective lval: fval & lval
  logic                  s1_vld_r;    // set once a real sample has been captured

  // FSM and counters
  state_t                state_r;
  logic [LINE_W-1:0]     line_cnt_r;
  logic [PIX_W-1:0]      pix_cnt_r;

  // Per-sample decisions
  logic                  next_lval_s;
  state_t                state_base_s;
  state_t                state_nx_s;
  logic [LINE_W-1:0]     lines_s;
  logic                  start_s;
  logic                  cont_s;
  logic                  frame_end_s;
  logic                  sop_s;
  logic                  drop_s;
  logic                  fwd_s;
  logic [PIX_W-1:0]      pix_next_s;
  logic                  at_width_s;
  logic                  eop_s;
  logic                  trunc_s;
  logic                  short_s;

  // The sample arriving behind stage 1 decides whether the stage-1 pixel ends
  // its line.
  assign next_lval_s = cam_fval & cam_lval;

  // Stage 1: capture the sensor sample with lval qualified by fval.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_r <= {DATA_WIDTH{1'b0}};
      s1_fval_r <= 1'b0;
      s1_lval_r <= 1'b0;
      s1_vld_r  <= 1'b0;
    end else begin
      s1_data_r <= cam_data;
      s1_fval_r <= cam_fval;
      s1_lval_r <= cam_fval & cam_lval;
      s1_vld_r  <= 1'b1;
    end
  end

  // Classify the stage-1 sample against the current state and pick the next state.
  always_comb begin
    state_base_s = state_r;
    lines_s      = line_cnt_r;
    start_s      = 1'b0;
    cont_s       = 1'b0;
    frame_end_s  = 1'b0;

    case (state_r)
      ST_SYNC: begin
        // Reset values of stage 1 are not a real sample, so wait for s1_vld_r.
        if (s1_vld_r && !s1_fval_r) begin
          state_base_s = ST_WAIT_FRAME;
        end else begin
          state_base_s = ST_SYNC;
        end
      end
      ST_WAIT_FRAME: begin
        // A line may begin on the same sample as the fval rising edge.
        // The line count is treated as already cleared for that sample.
        lines_s = LINE_ZERO;
        if (s1_fval_r) begin
          start_s      = s1_lval_r;
          state_base_s = ST_WAIT_LINE;
        end else begin
          state_base_s = ST_WAIT_FRAME;
        end
      end
      ST_WAIT_LINE: begin
        if (!s1_fval_r) begin
          frame_end_s  = 1'b1;
          state_base_s = ST_WAIT_FRAME;
        end else begin
          start_s      = s1_lval_r;
          state_base_s = ST_WAIT_LINE;
        end
      end
      ST_IN_LINE: begin
        // The look-ahead normally leaves IN_LINE before lval drops.
        // The other branches are a safety net.
        if (!s1_fval_r) begin
          frame_end_s  = 1'b1;
          state_base_s = ST_WAIT_FRAME;
        end else if (s1_lval_r) begin
          cont_s       = 1'b1;
          state_base_s = ST_IN_LINE;
        end else begin
          state_base_s = ST_WAIT_LINE;
        end
      end
      ST_TRUNC: begin
        if (!s1_fval_r) begin
          frame_end_s  = 1'b1;
          state_base_s = ST_WAIT_FRAME;
        end else if (!s1_lval_r) begin
          state_base_s = ST_WAIT_LINE;
        end else begin
          state_base_s = ST_TRUNC;
        end
      end
      ST_DROP: begin
        if (!s1_fval_r) begin
          frame_end_s  = 1'b1;
          state_base_s = ST_WAIT_FRAME;
        end else begin
          state_base_s = ST_DROP;
        end
      end
      default: begin
        state_base_s = ST_SYNC;
      end
    endcase

    // A new line is forwarded only while the frame still has room.
    // Otherwise the rest of the frame is dropped.
    sop_s  = start_s & (lines_s < FRAME_LINES_C);
    drop_s = start_s & ~(lines_s < FRAME_LINES_C);
    fwd_s  = sop_s | cont_s;

    if (sop_s) begin
      pix_next_s = PIX_ONE;
    end else begin
      pix_next_s = pix_cnt_r + PIX_ONE;
    end
    at_width_s = (pix_next_s == LINE_WIDTH_C);

    // End of line: lval drops behind this pixel, or the width limit is reached.
    // Reaching the limit while lval stays high truncates the line.
    eop_s   = fwd_s & (~next_lval_s | at_width_s);
    trunc_s = fwd_s & at_width_s & next_lval_s;
    short_s = fwd_s & ~next_lval_s & ~at_width_s;

    if (trunc_s) begin
      state_nx_s = ST_TRUNC;
    end else if (fwd_s) begin
      if (eop_s) begin
        state_nx_s = ST_WAIT_LINE;
      end else begin
        state_nx_s = ST_IN_LINE;
      end
    end else if (drop_s) begin
      state_nx_s = ST_DROP;
    end else begin
      state_nx_s = state_base_s;
    end
  end

  // Framing FSM: state, line and pixel counters, and the registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_SYNC;
      line_cnt_r <= LINE_ZERO;
      pix_cnt_r  <= {PIX_W{1'b0}};
      raw_data   <= {DATA_WIDTH{1'b0}};
      raw_valid  <= 1'b0;
      raw_sop    <= 1'b0;
      raw_eop    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      raw_valid <= fwd_s;
      raw_sop   <= sop_s;
      raw_eop   <= eop_s;

      if (fwd_s) begin
        raw_data  <= s1_data_r;
        pix_cnt_r <= pix_next_s;
      end else begin
        raw_data  <= raw_data;
        pix_cnt_r <= pix_cnt_r;
      end

      // Each forwarded line counts once. The first dropped line also counts
      // once, so an over-long frame never ends on exactly FRAME_LINES.
      if (sop_s || drop_s) begin
        line_cnt_r <= lines_s + LINE_ONE;
      end else if (state_r == ST_WAIT_FRAME && s1_fval_r) begin
        line_cnt_r <= LINE_ZERO;
      end else begin
        line_cnt_r <= line_cnt_r;
      end
    end
  end

`ifdef RAW_FRAMER_STATUS_EN
  // Sticky error flags and frame counter; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_short_line  <= 1'b0;
      err_long_line   <= 1'b0;
      err_frame_lines <= 1'b0;
      frame_cnt       <= 16'd0;
    end else begin
      if (frame_end_s) begin
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        frame_cnt <= frame_cnt;
      end
      err_short_line  <= short_s | (err_short_line & ~err_clr);
      err_long_line   <= trunc_s | (err_long_line & ~err_clr);
      err_frame_lines <= (frame_end_s & (line_cnt_r != FRAME_LINES_C))
                         | (err_frame_lines & ~err_clr);
    end
  end
`else
  assign err_short_line  = 1'b0;
  assign err_long_line   = 1'b0;
  assign err_frame_lines = 1'b0;
  assign frame_cnt       = 16'd0;

  // Status inputs and events have no consumer in this build.
  logic status_unused_s;
  assign status_unused_s = ^{err_clr, frame_end_s, short_s, trunc_s};
`endif

endmodule

// File: tb/tb_raw_line_framer.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for raw_line_framer with a reduced geometry (16-pixel
// lines, 6-line frames). Frames are described as lists of line lengths.
// The reference model derives the expected pixel stream and status flags from
// the framing rules: at most FRAME_LINES forwarded lines, at most LINE_WIDTH
// pixels per line, and output two cycles after input. A monitor pops and
// compares each raw_valid pixel.
// -----------------------------------------------------------------------------
module tb_raw_line_framer;

  localparam int DW = 8;
  localparam int LW = 16;
  localparam int FL = 6;

`ifdef RAW_FRAMER_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] cam_data = '0;
  logic          cam_fval = 1'b0;
  logic          cam_lval = 1'b0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] raw_data;
  logic          raw_valid;
  logic          raw_sop;
  logic          raw_eop;
  logic          err_short_line;
  logic          err_long_line;
  logic          err_frame_lines;
  logic [15:0]   frame_cnt;

  raw_line_framer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .FRAME_LINES(FL)) dut (
    .clk(clk), .reset_n(reset_n), .cam_data(cam_data), .cam_fval(cam_fval),
    .cam_lval(cam_lval), .raw_data(raw_data), .raw_valid(raw_valid),
    .raw_sop(raw_sop), .raw_eop(raw_eop), .err_clr(err_clr),
    .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_frame_lines(err_frame_lines), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [31:0]   cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;

  // Reference status model
  bit          m_short = 1'b0;
  bit          m_long  = 1'b0;
  bit          m_frame = 1'b0;
  logic [15:0] m_fcnt  = 16'd0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output strobe must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (raw_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_valid", 32'(raw_valid), 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("data", 32'(raw_data), 32'(e.data));
          check("sop", 32'(raw_sop), 32'(e.sop));
          check("eop", 32'(raw_eop), 32'(e.eop));
          check("latency_cycle", cyc, e.cyc);
        end
      end else begin
        check("marks_without_valid", 32'({raw_sop, raw_eop}), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic l);
    tick();
    cam_fval = f;
    cam_lval = l;
    cam_data = DW'($urandom);
  endtask

  task automatic drive_line(input int len, input bit fwd);
    int   keep;
    exp_t e;
    keep = (len < LW) ? len : LW;
    for (int p = 0; p < len; p++) begin
      drive(1'b1, 1'b1);
      if (fwd && p < LW) begin
        e.data = cam_data;
        e.sop  = (p == 0);
        e.eop  = (p == keep - 1);
        e.cyc  = cyc + 32'd2;
        sb_q.push_back(e);
      end
    end
  endtask

  // One frame: optional lead blanking, lines separated by lval gaps, then fval
  // low. When cut is set, fval drops straight after the last pixel while lval
  // stays high. rel_line releases reset just before that line.
  task automatic drive_frame(input int lens[$], input bit live, input bit cut, input int rel_line);
    int lead;
    int gap;
    bit fwd;
    lead = int'($urandom_range(0, 2));
    for (int i = 0; i < lead; i++) drive(1'b1, 1'b0);
    for (int li = 0; li < lens.size(); li++) begin
      if (li == rel_line) reset_n = 1'b1;
      fwd = live && (li < FL);
      drive_line(lens[li], fwd);
      if (fwd && lens[li] < LW) m_short = 1'b1;
      if (fwd && lens[li] > LW) m_long = 1'b1;
      if (!(cut && li == lens.size() - 1)) begin
        gap = int'($urandom_range(1, 3));
        for (int g = 0; g < gap; g++) drive(1'b1, 1'b0);
      end
    end
    if (cut) drive(1'b0, 1'b1);
    if (live) begin
      m_fcnt = m_fcnt + 16'd1;
      if (lens.size() != FL) m_frame = 1'b1;
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic check_status();
    check("frame_cnt", 32'(frame_cnt), STATUS_EN ? 32'(m_fcnt) : 32'd0);
    check("err_short_line", 32'(err_short_line), STATUS_EN ? 32'(m_short) : 32'd0);
    check("err_long_line", 32'(err_long_line), STATUS_EN ? 32'(m_long) : 32'd0);
    check("err_frame_lines", 32'(err_frame_lines), STATUS_EN ? 32'(m_frame) : 32'd0);
  endtask

  task automatic clear_errors();
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_frame = 1'b0;
    tick();
    tick();
    check_status();
  endtask

  task automatic uniform_lines(output int lens[$], input int n, input int len);
    lens.delete();
    for (int i = 0; i < n; i++) lens.push_back(len);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run still active at time %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int lens[$];
    int wait_cnt;

    // Reset values while reset is held
    repeat (3) drive(1'b0, 1'b0);
    check("reset_raw_valid", 32'(raw_valid), 32'd0);
    check("reset_raw_sop", 32'(raw_sop), 32'd0);
    check("reset_raw_eop", 32'(raw_eop), 32'd0);
    check("reset_raw_data", 32'(raw_data), 32'd0);
    check_status();

    // Reset released mid-frame with 3 lines left: nothing is forwarded
    uniform_lines(lens, FL, LW);
    drive_frame(lens, 1'b0, 1'b0, 3);
    check_status();

    // Nominal frame of full-width lines
    uniform_lines(lens, FL, LW);
    drive_frame(lens, 1'b1, 1'b0, -1);
    check_status();

    // Over-long line is truncated at LINE_WIDTH
    uniform_lines(lens, FL, LW);
    lens[2] = LW + 2;
    drive_frame(lens, 1'b1, 1'b0, -1);
    check_status();
    clear_errors();

    // Too many lines, then too few; the sticky flag survives until cleared
    uniform_lines(lens, FL + 2, LW);
    drive_frame(lens, 1'b1, 1'b0, -1);
    check_status();
    uniform_lines(lens, FL - 1, LW);
    drive_frame(lens, 1'b1, 1'b0, -1);
    check_status();
    clear_errors();

    // 1-pixel line, then a line cut by fval falling at pixel 6
    lens.delete();
    lens.push_back(1);
    lens.push_back(6);
    drive_frame(lens, 1'b1, 1'b1, -1);
    check_status();
    clear_errors();

    // Randomised frames
    for (int f = 0; f < 12; f++) begin
      int nl;
      bit cut;
      lens.delete();
      nl = int'($urandom_range(FL - 2, FL + 2));
      for (int i = 0; i < nl; i++) lens.push_back(int'($urandom_range(1, LW + 4)));
      cut = ($urandom_range(0, 3) == 0);
      drive_frame(lens, 1'b1, cut, -1);
      check_status();
      if ($urandom_range(0, 2) == 0) clear_errors();
    end

    wait_cnt = 0;
    while (sb_q.size() != 0 && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
